hazard_forward_unit: RTL and testbench

Producer side of the EX operand-forwarding interface: generates the 2-bit `ForwardA_EX`/`ForwardB_EX` selects consumed by the EX operand muxes, plus the pipeline stall and bubble controls. It keeps its own registered shadow of register-usage information for the EX, MEM and WB stages, fed from decode each cycle. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and runs on the core clock.

---
 rtl/hazard_forward_unit.sv | 110 +++++++++++
 tb/tb_hazard_forward_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Load-use / branch hazard detection and EX operand-forward select generation.
// Tracks a registered shadow of destination/source usage for the EX, MEM and WB stages.
module hazard_forward_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [4:0]  Write_Reg_ID,
    input  logic        RegWrite_ID,
    input  logic        MemRead_ID,
    input  logic        Branch_ID,
    input  logic        Flush_ID,
    output logic [1:0]  ForwardA_EX,
    output logic [1:0]  ForwardB_EX,
    output logic        Stall_ID,
    output logic        Bubble_EX,
    output logic [15:0] Stall_Count
);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } ex_shadow_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       reg_write;
        logic       mem_read;
    } mem_shadow_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       reg_write;
    } wb_shadow_t;

    localparam logic [1:0] FWD_ID_EX = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;

    ex_shadow_t  ex_q;
    mem_shadow_t mem_q;
    wb_shadow_t  wb_q;

    logic use_rs;
    logic use_rt;
    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic branch_on_ex;
    logic branch_on_mem_load;

    // Register 0 is hardwired, so a zero source never creates a dependency.
    assign use_rs  = (Rs_ID != 5'd0);
    assign use_rt  = (Rt_ID != 5'd0);
    assign ex_hit  = (use_rs && (ex_q.dst == Rs_ID)) || (use_rt && (ex_q.dst == Rt_ID));
    assign mem_hit = (use_rs && (mem_q.dst == Rs_ID)) || (use_rt && (mem_q.dst == Rt_ID));

    assign load_use           = ex_q.mem_read && ex_q.reg_write && ex_hit;
    assign branch_on_ex       = Branch_ID && ex_q.reg_write && ex_hit;
    assign branch_on_mem_load = Branch_ID && mem_q.mem_read && mem_q.reg_write && mem_hit;

    assign Stall_ID  = (load_use || branch_on_ex || branch_on_mem_load) && !Flush_ID;
    assign Bubble_EX = Stall_ID || Flush_ID;

    // A load in MEM has no data yet, so it falls through to the WB check.
    function automatic logic [1:0] forward_select(input logic [4:0]  src,
                                                  input mem_shadow_t mem,
                                                  input wb_shadow_t  wb);
        if ((src != 5'd0) && mem.reg_write && !mem.mem_read && (mem.dst == src))
            return FWD_MEM;
        else if ((src != 5'd0) && wb.reg_write && (wb.dst == src))
            return FWD_WB;
        else
            return FWD_ID_EX;
    endfunction

    assign ForwardA_EX = forward_select(ex_q.rs, mem_q, wb_q);
    assign ForwardB_EX = forward_select(ex_q.rt, mem_q, wb_q);

    // NOTE: non-blocking assignments let every stage read its predecessor's old value on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            Stall_Count <= 16'd0;
        end else begin
            wb_q.dst        <= mem_q.dst;
            wb_q.reg_write  <= mem_q.reg_write;
            mem_q.dst       <= ex_q.dst;
            mem_q.reg_write <= ex_q.reg_write;
            mem_q.mem_read  <= ex_q.mem_read;
            if (Bubble_EX) begin
                ex_q <= '0;
            end else begin
                ex_q.rs        <= Rs_ID;
                ex_q.rt        <= Rt_ID;
                ex_q.dst       <= Write_Reg_ID;
                ex_q.reg_write <= RegWrite_ID;
                ex_q.mem_read  <= MemRead_ID;
            end
            if (Stall_ID && (Stall_Count != 16'hFFFF))
                Stall_Count <= Stall_Count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: per-cycle vector table through a scoreboard queue,
// followed by reset-mid-stall and counter-saturation sequences.
module tb_hazard_forward_unit;

    logic        Clk;
    logic        Reset;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic [4:0]  Write_Reg_ID;
    logic        RegWrite_ID;
    logic        MemRead_ID;
    logic        Branch_ID;
    logic        Flush_ID;
    logic [1:0]  ForwardA_EX;
    logic [1:0]  ForwardB_EX;
    logic        Stall_ID;
    logic        Bubble_EX;
    logic [15:0] Stall_Count;

    hazard_forward_unit dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Rs_ID        (Rs_ID),
        .Rt_ID        (Rt_ID),
        .Write_Reg_ID (Write_Reg_ID),
        .RegWrite_ID  (RegWrite_ID),
        .MemRead_ID   (MemRead_ID),
        .Branch_ID    (Branch_ID),
        .Flush_ID     (Flush_ID),
        .ForwardA_EX  (ForwardA_EX),
        .ForwardB_EX  (ForwardB_EX),
        .Stall_ID     (Stall_ID),
        .Bubble_EX    (Bubble_EX),
        .Stall_Count  (Stall_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wd;
        logic        rw;
        logic        mr;
        logic        br;
        logic        fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        bu;
        logic [15:0] cnt;
    } vec_t;

    localparam int NUM_VECS = 32;

    vec_t vecs [NUM_VECS];
    vec_t exp_q [$];
    int   tests_run = 0;
    int   failures  = 0;

    function automatic vec_t mk(input int rs, input int rt, input int wd, input bit rw, input bit mr,
                                input bit br, input bit fl, input int fa, input int fb, input bit st,
                                input bit bu, input int cnt);
        vec_t v;
        v.rs  = 5'(rs);
        v.rt  = 5'(rt);
        v.wd  = 5'(wd);
        v.rw  = rw;
        v.mr  = mr;
        v.br  = br;
        v.fl  = fl;
        v.fa  = 2'(fa);
        v.fb  = 2'(fb);
        v.st  = st;
        v.bu  = bu;
        v.cnt = 16'(cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd,
                         input logic rw, input logic mr, input logic br, input logic fl);
        Rs_ID        = rs;
        Rt_ID        = rt;
        Write_Reg_ID = wd;
        RegWrite_ID  = rw;
        MemRead_ID   = mr;
        Branch_ID    = br;
        Flush_ID     = fl;
    endtask

    task automatic check_outputs(input string tag, input vec_t e);
        check({tag, " fwdA"},  16'(ForwardA_EX), 16'(e.fa));
        check({tag, " fwdB"},  16'(ForwardB_EX), 16'(e.fb));
        check({tag, " stall"}, 16'(Stall_ID),    16'(e.st));
        check({tag, " bubble"},16'(Bubble_EX),   16'(e.bu));
        check({tag, " count"}, Stall_Count,      e.cnt);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //                rs  rt  wd  rw mr br fl  fa fb st bu cnt
        vecs[0]  = mk( 1,  2,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // add $3,$1,$2
        vecs[1]  = mk( 3,  5,  4, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // sub $4,$3,$5
        vecs[2]  = mk( 0,  0,  0, 0, 0, 0, 0, 2, 0, 0, 0, 0);  // sub in EX: A from MEM
        vecs[3]  = mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk( 1,  1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // add $3
        vecs[5]  = mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // nop
        vecs[6]  = mk( 5,  3,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // or $6,$5,$3
        vecs[7]  = mk( 0,  0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0);  // B from WB
        vecs[8]  = mk( 1,  1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // add $3
        vecs[9]  = mk( 2,  2,  3, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // add $3 again
        vecs[10] = mk( 5,  3,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // or $6,$5,$3
        vecs[11] = mk( 0,  0,  0, 0, 0, 0, 0, 0, 2, 0, 0, 0);  // MEM beats WB
        vecs[12] = mk( 1,  0,  2, 1, 1, 0, 0, 0, 0, 0, 0, 0);  // lw $2
        vecs[13] = mk( 2,  2,  7, 1, 0, 0, 0, 0, 0, 1, 1, 0);  // add $7,$2,$2 stalls
        vecs[14] = mk( 2,  2,  7, 1, 0, 0, 0, 0, 0, 0, 0, 1);  // held add proceeds
        vecs[15] = mk( 0,  0,  0, 0, 0, 0, 0, 1, 1, 0, 0, 1);  // both from WB
        vecs[16] = mk( 1,  0,  8, 1, 1, 0, 0, 0, 0, 0, 0, 1);  // lw $8
        vecs[17] = mk( 8,  0,  0, 0, 0, 1, 0, 0, 0, 1, 1, 1);  // beq $8,$0 stall 1
        vecs[18] = mk( 8,  0,  0, 0, 0, 1, 0, 0, 0, 1, 1, 2);  // stall 2
        vecs[19] = mk( 8,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 3);  // released
        vecs[20] = mk( 1,  1,  8, 1, 0, 0, 0, 0, 0, 0, 0, 3);  // add $8
        vecs[21] = mk( 8,  0,  0, 0, 0, 1, 0, 0, 0, 1, 1, 3);  // beq stalls once
        vecs[22] = mk( 8,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 4);  // released
        vecs[23] = mk( 1,  1,  0, 1, 0, 0, 0, 1, 0, 0, 0, 4);  // add $0; beq A from WB
        vecs[24] = mk( 0,  0,  4, 1, 0, 0, 0, 0, 0, 0, 0, 4);  // sub $4,$0,$0
        vecs[25] = mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4);  // $0 never forwarded
        vecs[26] = mk( 1,  0,  0, 1, 1, 0, 0, 0, 0, 0, 0, 4);  // lw $0
        vecs[27] = mk( 0,  0,  5, 1, 0, 0, 0, 0, 0, 0, 0, 4);  // $0 never stalls
        vecs[28] = mk( 1,  0,  9, 1, 1, 0, 0, 0, 0, 0, 0, 4);  // lw $9
        vecs[29] = mk( 9,  9, 10, 1, 0, 0, 1, 0, 0, 0, 1, 4);  // flushed consumer
        vecs[30] = mk(10,  0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 4);  // beq $10 sees empty EX
        vecs[31] = mk( 0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 4);  // empty MEM

        Reset = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < NUM_VECS; i++) begin
            @(posedge Clk);
            #1;
            Reset = 1'b0;
            drive(vecs[i].rs, vecs[i].rt, vecs[i].wd, vecs[i].rw, vecs[i].mr, vecs[i].br, vecs[i].fl);
            exp_q.push_back(vecs[i]);
            @(negedge Clk);
            if (exp_q.size() == 0) begin
                check($sformatf("row%0d scoreboard empty", i), 16'd0, 16'd1);
            end else begin
                check_outputs($sformatf("row%0d", i), exp_q.pop_front());
            end
        end

        // Reset arriving during a load-use stall.
        @(posedge Clk);
        #1;
        drive(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        drive(5'd2, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_stall stall", 16'(Stall_ID), 16'd1);
        check("rst_stall bubble", 16'(Bubble_EX), 16'd1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check_outputs("post_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Saturation: lw $2 then beq $2 gives two stall cycles per three.
        for (int n = 0; n < 32769; n++) begin
            drive(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
            @(posedge Clk);
            #1;
            drive(5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(posedge Clk);
            #1;
            @(posedge Clk);
            #1;
            if (n == 32766)
                check("count before saturation", Stall_Count, 16'd65534);
        end
        check("count saturated", Stall_Count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
